square_draw_arbiter: RTL and testbench
======================================

// Module: square_draw_arbiter
// PURPOSE
//  Shares one square_drawer between NUM_REQ clients (e.g. players/cursors) that each request a
//  SIZE x SIZE square at (x,y) in a given colour. Round-robin grant, sequences drawer start/done,
//  and forwards the drawer's coordinate stream as framebuffer pixel writes with the winner's colour.
//  Sits between game/control logic and the VGA framebuffer write port.
// PARAMETERS
//  NUM_REQ  2    number of requesters (2..8)
//  SIZE     10   square extent passed to the drawer (must equal the drawer's SIZE)
//  COLOR_W  1    pixel colour width
//  TIMEOUT  255  max BUSY cycles without drw_done before forced release (>= (SIZE+1)^2+2)
// PORTS
//  clk        in   1                  system clock
//  reset      in   1                  asynchronous, active-high reset
//  req        in   NUM_REQ            level request per client; held until its done_pulse
//  req_x      in   NUM_REQ*11         packed origin x, client i at [11*i +: 11]
//  req_y      in   NUM_REQ*11         packed origin y, same packing
//  req_color  in   NUM_REQ*COLOR_W    packed colour, client i at [COLOR_W*i +: COLOR_W]
//  gnt        out  NUM_REQ            one-hot grant, high START..BUSY for the served client
//  done_pulse out  NUM_REQ            one-cycle completion strobe to the served client
//  drw_start  out  1                  start to drawer
//  drw_x0     out  11                 origin to drawer (registered)
//  drw_y0     out  11                 origin to drawer (registered)
//  drw_x      in   11                 drawer current x
//  drw_y      in   11                 drawer current y
//  drw_done   in   1                  drawer done
//  pix_x      out  11                 framebuffer write x (= drw_x)
//  pix_y      out  11                 framebuffer write y (= drw_y)
//  pix_color  out  COLOR_W            colour latched at grant
//  pix_wr     out  1                  framebuffer write enable
//  busy       out  1                  high in any state other than IDLE
//  timeout_err out 1                  sticky: a draw was force-released
// BEHAVIOUR
//  - Reset (async): state=IDLE, gnt=0, done_pulse=0, drw_start=0, drw_x0=drw_y0=0, pix_color=0,
//    pix_wr=0, busy=0, timeout_err=0, last-grant pointer=NUM_REQ-1 (client 0 has priority first).
//    Reset mid-draw aborts without done_pulse; drawer must share the same reset net.
//  - States: IDLE -> START -> BUSY -> RELEASE -> IDLE.
//  - IDLE: if any req[i], pick first set bit scanning last+1, last+2, .. mod NUM_REQ; on the clock
//    edge latch its req_x/req_y into drw_x0/drw_y0, colour into pix_color, set gnt one-hot, go START.
//    No req: stay IDLE. Requests arriving simultaneously resolve purely by the pointer.
//  - START (1 cycle): drw_start=1. Next cycle -> BUSY; drw_x0/drw_y0 held stable until next grant.
//  - BUSY: pix_wr = ~drw_done; pix_x/pix_y follow drw_x/drw_y combinationally. First BUSY cycle
//    carries (x0,y0); (SIZE+1)^2 writes for a full square. drw_done=1 -> RELEASE.
//    Cycle counter starts at 0 on BUSY entry; reaching TIMEOUT -> RELEASE, timeout_err<=1.
//  - RELEASE (1 cycle): gnt=0, done_pulse[granted]=1, pix_wr=0, pointer<=granted index -> IDLE.
//    IDLE->START therefore occurs >=2 cycles after drw_done, letting the drawer return to idle.
//  - Dropping req during START/BUSY does not abort; done_pulse is still issued.
//  - Coordinates are not clipped; x0+SIZE overflow beyond 11 bits wraps in the drawer.
//  - pix_wr, drw_start, done_pulse are never high outside BUSY/START/RELEASE respectively.
// TESTING
//  1 Single req[0], x=20,y=20, color=1 -> drw_start one cycle after grant, 121 pix_wr cycles
//    (20,20)..(30,30) row-major, done_pulse[0] 1 cycle, busy low after.
//  2 req=2'b11 held same cycle from reset -> client 0 served first, then client 1; each gets
//    one done_pulse; with both held continuously grants alternate 0,1,0,1.
//  3 req[1] raised while client 0 BUSY -> no gnt change mid-draw; client 1 granted from IDLE
//    after client 0's RELEASE; pix_color switches only at new grant.
//  4 Drawer stub that never asserts drw_done -> after 255 BUSY cycles RELEASE, done_pulse, timeout_err=1
//    and stays 1 through later good draws until reset.
//  5 Assert reset mid-BUSY at pixel 50 -> all outputs zero immediately (async), no done_pulse;
//    after release, req[1] alone is granted correctly and draws a full 121-pixel square.
//  6 x=0,y=0 corner origin -> first write (0,0), last (10,10), no extra or missing pixels.

Source files
------------

// File: rtl/square_draw_arbiter.sv
// Round-robin arbiter sharing one square drawer between NUM_REQ clients.
// Sequences drawer start/done and forwards the coordinate stream as pixel writes.
module square_draw_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned SIZE    = 10,
  parameter int unsigned COLOR_W = 1,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*11-1:0]      req_x,
  input  logic [NUM_REQ*11-1:0]      req_y,
  input  logic [NUM_REQ*COLOR_W-1:0] req_color,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [NUM_REQ-1:0]         done_pulse,
  output logic                       drw_start,
  output logic [10:0]                drw_x0,
  output logic [10:0]                drw_y0,
  input  logic [10:0]                drw_x,
  input  logic [10:0]                drw_y,
  input  logic                       drw_done,
  output logic [10:0]                pix_x,
  output logic [10:0]                pix_y,
  output logic [COLOR_W-1:0]         pix_color,
  output logic                       pix_wr,
  output logic                       busy,
  output logic                       timeout_err
);

  // A timeout shorter than one full square would abort every legal draw.
  localparam int unsigned MinTimeout = (SIZE + 1) * (SIZE + 1) + 2;
  localparam int unsigned TimeoutEff = (TIMEOUT < MinTimeout) ? MinTimeout : TIMEOUT;
  localparam int unsigned CntW       = $clog2(TimeoutEff);
  localparam int unsigned IdxW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {StIdle, StStart, StBusy, StRelease} state_e;

  state_e               state_q, state_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [IdxW-1:0]      last_q, last_d;
  logic [10:0]          x0_q, x0_d;
  logic [10:0]          y0_q, y0_d;
  logic [COLOR_W-1:0]   col_q, col_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 terr_q, terr_d;

  logic                 pick_valid;
  logic [IdxW-1:0]      pick_idx;
  logic [IdxW-1:0]      cand;
  logic [NUM_REQ-1:0]   onehot;

  // Scan last+1, last+2, ... so the client served last has lowest priority.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IdxW'((32'(last_q) + k) % NUM_REQ);
      if (!pick_valid && req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    x0_d    = x0_q;
    y0_d    = y0_q;
    col_d   = col_q;
    cnt_d   = cnt_q;
    terr_d  = terr_q;
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          idx_d   = pick_idx;
          x0_d    = req_x[11*pick_idx +: 11];
          y0_d    = req_y[11*pick_idx +: 11];
          col_d   = req_color[COLOR_W*pick_idx +: COLOR_W];
          state_d = StStart;
        end
      end
      StStart: begin
        cnt_d   = '0;
        state_d = StBusy;
      end
      StBusy: begin
        if (drw_done) begin
          state_d = StRelease;
        end else if (cnt_q == CntW'(TimeoutEff - 1)) begin
          state_d = StRelease;
          terr_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRelease: begin
        last_d  = idx_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      last_q  <= IdxW'(NUM_REQ - 1);
      x0_q    <= '0;
      y0_q    <= '0;
      col_q   <= '0;
      cnt_q   <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      col_q   <= col_d;
      cnt_q   <= cnt_d;
      terr_q  <= terr_d;
    end
  end

  always_comb begin
    onehot      = NUM_REQ'(1) << idx_q;
    gnt         = ((state_q == StStart) || (state_q == StBusy)) ? onehot : '0;
    done_pulse  = (state_q == StRelease) ? onehot : '0;
    drw_start   = (state_q == StStart);
    pix_wr      = (state_q == StBusy) && !drw_done;
    busy        = (state_q != StIdle);
    pix_x       = drw_x;
    pix_y       = drw_y;
    drw_x0      = x0_q;
    drw_y0      = y0_q;
    pix_color   = col_q;
    timeout_err = terr_q;
  end

endmodule

// File: tb/tb_square_draw_arbiter.sv
// Bench for square_draw_arbiter: drawer stub, draw-level timing model compared every cycle,
// plus literal pins on first/last pixel, pixel counts and grant order.
module tb_square_draw_arbiter;

  localparam int N = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req;
  logic [21:0] req_x, req_y;
  logic [1:0]  req_color;
  logic [1:0]  gnt, done_pulse;
  logic        drw_start, drw_done, pix_wr, busy, timeout_err;
  logic [10:0] drw_x0, drw_y0, drw_x, drw_y, pix_x, pix_y;
  logic [0:0]  pix_color;

  always #5 clk = ~clk;

  square_draw_arbiter #(
    .NUM_REQ(2), .SIZE(10), .COLOR_W(1), .TIMEOUT(255)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .req_x(req_x), .req_y(req_y),
    .req_color(req_color), .gnt(gnt), .done_pulse(done_pulse), .drw_start(drw_start),
    .drw_x0(drw_x0), .drw_y0(drw_y0), .drw_x(drw_x), .drw_y(drw_y), .drw_done(drw_done),
    .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color), .pix_wr(pix_wr), .busy(busy),
    .timeout_err(timeout_err)
  );

  // Drawer stub: one pixel per cycle row-major after start, then a one-cycle done.
  // With hang_mode set it parks on the last pixel and never signals done.
  bit          hang_mode;
  logic [10:0] dx0, dy0;
  logic [3:0]  dcol, drow;
  logic        dact;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      dx0 <= '0; dy0 <= '0; dcol <= '0; drow <= '0; dact <= 1'b0; drw_done <= 1'b0;
    end else begin
      drw_done <= 1'b0;
      if (drw_start) begin
        dx0 <= drw_x0; dy0 <= drw_y0; dcol <= '0; drow <= '0; dact <= 1'b1;
      end else if (dact) begin
        if (dcol == 4'd10 && drow == 4'd10) begin
          if (!hang_mode) begin
            drw_done <= 1'b1;
            dact     <= 1'b0;
          end
        end else if (dcol == 4'd10) begin
          dcol <= '0;
          drow <= drow + 4'd1;
        end else begin
          dcol <= dcol + 4'd1;
        end
      end
    end
  end
  assign drw_x = dx0 + 11'(dcol);
  assign drw_y = dy0 + 11'(drow);

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Draw-level model: m_t counts cycles since the grant edge. START at t=0, pixels at
  // t=1..121, done cycle at t=122, RELEASE at t=123 (t=256 when the drawer hangs).
  bit          m_serv, m_hang, m_terr;
  int          m_t, m_rel, m_owner, m_last, npix;
  logic [10:0] m_x0, m_y0;
  logic        m_col;

  typedef struct { int owner; int nwr; int fx; int fy; int lx; int ly; } draw_t;
  draw_t log_q[$];
  int    wr_cnt, fx, fy, lx, ly;

  always @(posedge clk) begin
    if (reset) begin
      m_serv = 0; m_hang = 0; m_terr = 0; m_t = 0; m_rel = 0; m_owner = 0;
      m_last = N - 1; m_x0 = '0; m_y0 = '0; m_col = 1'b0;
    end else if (m_serv) begin
      if (m_t == m_rel) begin
        m_serv = 0;
      end else begin
        m_t++;
        if (m_hang && m_t == m_rel) m_terr = 1;
      end
    end else if (req != 2'b00) begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_last + k) % N;
        if (req[c]) begin
          m_owner = c;
          break;
        end
      end
      m_last = m_owner;
      m_serv = 1; m_t = 0;
      m_x0  = req_x[11*m_owner +: 11];
      m_y0  = req_y[11*m_owner +: 11];
      m_col = req_color[m_owner];
      m_hang = hang_mode;
      m_rel  = hang_mode ? 256 : 123;
    end

    #1;
    npix = m_hang ? 255 : 121;
    chk("busy", busy, m_serv);
    chk("drw_start", drw_start, m_serv && m_t == 0);
    chk("gnt", gnt, (m_serv && m_t < m_rel) ? (2'b01 << m_owner) : 2'b00);
    chk("done_pulse", done_pulse, (m_serv && m_t == m_rel) ? (2'b01 << m_owner) : 2'b00);
    chk("pix_wr", pix_wr, m_serv && m_t >= 1 && m_t <= npix);
    chk("pix_color", pix_color, m_col);
    chk("drw_x0", drw_x0, m_x0);
    chk("drw_y0", drw_y0, m_y0);
    chk("timeout_err", timeout_err, m_terr);
    if (m_serv && m_t >= 1 && m_t <= 121) begin
      chk("pix_x", pix_x, 11'(m_x0 + (m_t - 1) % 11));
      chk("pix_y", pix_y, 11'(m_y0 + (m_t - 1) / 11));
    end

    if (reset) begin
      wr_cnt = 0;
    end else begin
      if (pix_wr) begin
        if (wr_cnt == 0) begin
          fx = int'(pix_x); fy = int'(pix_y);
        end
        lx = int'(pix_x); ly = int'(pix_y);
        wr_cnt++;
      end
      if (done_pulse != 2'b00) begin
        log_q.push_back('{done_pulse[1] ? 1 : 0, wr_cnt, fx, fy, lx, ly});
        wr_cnt = 0;
      end
    end
  end

  task automatic set_client(input int i, input int x, input int y, input int c);
    req_x[11*i +: 11] = 11'(x);
    req_y[11*i +: 11] = 11'(y);
    req_color[i]      = c[0];
  endtask

  task automatic wait_done(input int client, input int budget);
    bit got = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #2;
      if (done_pulse[client]) begin
        got = 1;
        break;
      end
    end
    chk("wait_done", got, 1);
  endtask

  task automatic wait_any_done(input int budget);
    bit got = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #2;
      if (done_pulse != 2'b00) begin
        got = 1;
        break;
      end
    end
    chk("wait_any_done", got, 1);
  endtask

  task automatic wait_writes(input int n, input int budget);
    bit got = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #2;
      if (wr_cnt >= n) begin
        got = 1;
        break;
      end
    end
    chk("wait_writes", got, 1);
  endtask

  task automatic pin_draw(input string nm, input int owner, input int nwr, input int efx,
                          input int efy, input int elx, input int ely);
    draw_t d;
    if (log_q.size() == 0) begin
      chk({nm, "_logged"}, 0, 1);
    end else begin
      d = log_q[$];
      chk({nm, "_owner"}, d.owner, owner);
      chk({nm, "_npix"}, d.nwr, nwr);
      chk({nm, "_first_x"}, d.fx, efx);
      chk({nm, "_first_y"}, d.fy, efy);
      chk({nm, "_last_x"}, d.lx, elx);
      chk({nm, "_last_y"}, d.ly, ely);
    end
  endtask

  int exp_ord[4] = '{0, 1, 0, 1};
  int base;

  initial begin
    reset = 1'b1; req = 2'b00; hang_mode = 0;
    req_x = '0; req_y = '0; req_color = '0;
    wr_cnt = 0; fx = 0; fy = 0; lx = 0; ly = 0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_gnt", gnt, 0);
    chk("rst_pix_wr", pix_wr, 0);
    chk("rst_drw_x0", drw_x0, 0);
    reset = 1'b0;

    // Single client draw at (20,20).
    set_client(0, 20, 20, 1);
    @(negedge clk) req = 2'b01;
    wait_done(0, 400);
    @(negedge clk) req = 2'b00;
    pin_draw("t1", 0, 121, 20, 20, 30, 30);
    repeat (4) @(negedge clk);
    chk("t1_idle_busy", busy, 0);

    // Both clients requesting straight out of reset: alternate 0,1,0,1.
    reset = 1'b1;
    set_client(1, 100, 50, 0);
    req = 2'b11;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    base = log_q.size();
    for (int i = 0; i < 4; i++) wait_any_done(400);
    @(negedge clk) req = 2'b00;
    for (int i = 0; i < 4; i++) begin
      if (log_q.size() > base + i) chk("t2_order", log_q[base+i].owner, exp_ord[i]);
      else chk("t2_order_logged", 0, 1);
    end

    // Client 1 joins while client 0 is mid-draw.
    set_client(0, 200, 100, 1);
    set_client(1, 300, 200, 0);
    @(negedge clk) req = 2'b01;
    wait_writes(30, 200);
    @(negedge clk) req = 2'b11;
    wait_done(0, 400);
    pin_draw("t3a", 0, 121, 200, 100, 210, 110);
    @(negedge clk) req = 2'b10;
    wait_done(1, 400);
    @(negedge clk) req = 2'b00;
    pin_draw("t3b", 1, 121, 300, 200, 310, 210);

    // Drawer never finishes: forced release after 255 busy cycles, sticky error.
    @(negedge clk) begin hang_mode = 1; req = 2'b01; end
    wait_done(0, 600);
    @(negedge clk) begin req = 2'b00; hang_mode = 0; end
    pin_draw("t4", 0, 255, 200, 100, 210, 110);
    chk("t4_timeout_err", timeout_err, 1);
    @(negedge clk) req = 2'b10;
    wait_done(1, 400);
    @(negedge clk) req = 2'b00;
    pin_draw("t4_after", 1, 121, 300, 200, 310, 210);
    chk("t4_err_sticky", timeout_err, 1);

    // Reset in the middle of a draw, then a clean draw from client 1.
    @(negedge clk) req = 2'b01;
    wait_writes(50, 200);
    @(negedge clk) reset = 1'b1;
    #1;
    chk("t5_gnt", gnt, 0);
    chk("t5_done", done_pulse, 0);
    chk("t5_start", drw_start, 0);
    chk("t5_pix_wr", pix_wr, 0);
    chk("t5_busy", busy, 0);
    chk("t5_terr", timeout_err, 0);
    chk("t5_x0", drw_x0, 0);
    chk("t5_y0", drw_y0, 0);
    chk("t5_color", pix_color, 0);
    chk("t5_pix_x", pix_x, 0);
    chk("t5_pix_y", pix_y, 0);
    @(negedge clk) req = 2'b10;
    @(negedge clk) reset = 1'b0;
    base = log_q.size();
    wait_done(1, 400);
    @(negedge clk) req = 2'b00;
    chk("t5_one_draw", log_q.size(), base + 1);
    pin_draw("t5", 1, 121, 300, 200, 310, 210);

    // Corner origin.
    set_client(0, 0, 0, 1);
    @(negedge clk) req = 2'b01;
    wait_done(0, 400);
    @(negedge clk) req = 2'b00;
    pin_draw("t6", 0, 121, 0, 0, 10, 10);

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
